fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32 pipeline, sitting directly upstream of the decode stage and its control unit. Owns the program counter, issues word fetches to instruction memory over a req/ready/valid handshake with one request outstanding, and drives the IF/ID pipeline register (instruction, PC, PC+4, valid) that decode consumes. Honours decode stall and flush, and execute-stage branch/jump redirects, including discarding an in-flight fetch on redirect.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/if_id_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 140 ++++++++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: word size, the canonical NOP and the fetch FSM states.
package riscv_pkg;

    parameter int unsigned XLEN = 32;

    // addi x0, x0, 0
    parameter logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } fetch_state_e;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus: req/ready request channel plus rvalid/rdata response.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush beats stall; an idle cycle without capture leaves a bubble.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            capture_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic            valid_q;

    // Register update in priority order: reset, flush, stall, capture, bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q    <= NOP;
            pc_q       <= '0;
            pc_plus4_q <= 32'd4;
            valid_q    <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (stall_i) begin
            instr_q    <= instr_q;
            pc_q       <= pc_q;
            pc_plus4_q <= pc_plus4_q;
            valid_q    <= valid_q;
        end else if (capture_i) begin
            instr_q    <= instr_i;
            pc_q       <= pc_i;
            pc_plus4_q <= pc_plus4(pc_i);
            valid_q    <= 1'b1;
        end else begin
            // Bubble: PC fields keep their last value and are meaningless while valid is low.
            instr_q <= NOP;
            valid_q <= 1'b0;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: owns PCF, runs one-outstanding fetches and feeds the IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    fetch_stage_if.master       imem,
    input  logic                StallD,
    input  logic                FlushD,
    input  logic                PCSrcE,
    input  logic [XLEN-1:0]     PCTargetE,
    output logic [XLEN-1:0]     InstrD,
    output logic [XLEN-1:0]     PCD,
    output logic [XLEN-1:0]     PCPlus4D,
    output logic                ValidD
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic            req_q;
    logic [XLEN-1:0] addr_q;

    logic            accept;
    logic [XLEN-1:0] target;
    logic            capture;
    logic [XLEN-1:0] capture_instr;
    logic            unused_tgt_lsbs;

    assign target          = {PCTargetE[XLEN-1:2], 2'b00};
    assign unused_tgt_lsbs = ^PCTargetE[1:0];
    assign accept          = req_q && imem.imem_ready;

    // Next-state, PC and capture decisions for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        pcf_d         = pcf_q;
        drop_d        = drop_q;
        hold_d        = hold_q;
        capture       = 1'b0;
        capture_instr = imem.imem_rdata;
        case (state_q)
            StIdle: begin
                // A stale response arriving here belongs to a fetch abandoned by reset.
                state_d = StReq;
            end
            StReq: begin
                if (accept) begin
                    state_d = StWait;
                    if (PCSrcE) begin
                        drop_d = 1'b1;
                        pcf_d  = target;
                    end
                end else if (PCSrcE) begin
                    pcf_d = target;
                end
            end
            StWait: begin
                if (imem.imem_rvalid) begin
                    if (drop_q || PCSrcE) begin
                        drop_d  = 1'b0;
                        state_d = StReq;
                        if (PCSrcE) begin
                            pcf_d = target;
                        end
                    end else if (FlushD) begin
                        // PCF untouched: the same PC is fetched again.
                        state_d = StReq;
                    end else if (StallD) begin
                        hold_d  = imem.imem_rdata;
                        state_d = StHold;
                    end else begin
                        capture = 1'b1;
                        pcf_d   = pc_plus4(pcf_q);
                        state_d = StReq;
                    end
                end else if (PCSrcE) begin
                    pcf_d  = target;
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                if (PCSrcE || FlushD) begin
                    state_d = StReq;
                    if (PCSrcE) begin
                        pcf_d = target;
                    end
                end else if (!StallD) begin
                    capture       = 1'b1;
                    capture_instr = hold_q;
                    pcf_d         = pc_plus4(pcf_q);
                    state_d       = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state plus registered request outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pcf_q   <= RESET_PC;
            drop_q  <= 1'b0;
            hold_q  <= NOP;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            drop_q  <= drop_d;
            hold_q  <= hold_d;
            req_q   <= (state_d == StReq);
            addr_q  <= pcf_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    if_id_reg u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (FlushD),
        .stall_i    (StallD),
        .capture_i  (capture),
        .instr_i    (capture_instr),
        .pc_i       (pcf_q),
        .instr_o    (InstrD),
        .pc_o       (PCD),
        .pc_plus4_o (PCPlus4D),
        .valid_o    (ValidD)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a one-cycle instruction memory model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    logic        mem_ready;
    logic        mem_go;
    logic        pend;
    logic [31:0] paddr;

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem      (bus),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: responds with addr ^ A5A5_0000 one cycle after acceptance (or later if held).
    assign bus.imem_ready  = mem_ready;
    assign bus.imem_rvalid = pend && mem_go;
    assign bus.imem_rdata  = paddr ^ 32'hA5A5_0000;

    initial begin
        pend  = 1'b0;
        paddr = '0;
    end

    always @(posedge clk) begin
        if (pend && mem_go) pend <= 1'b0;
        if (bus.imem_req && bus.imem_ready) begin
            pend  <= 1'b1;
            paddr <= bus.imem_addr;
        end
    end

    typedef struct {
        logic        st;
        logic        fl;
        logic        pc;
        logic [31:0] tgt;
        logic        rdy;
        logic        go;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] einstr;
        logic [31:0] epcd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic st, input logic fl, input logic pc,
                                input logic [31:0] tgt, input logic rdy, input logic go,
                                input logic ereq, input logic [31:0] eaddr,
                                input logic evalid, input logic [31:0] einstr,
                                input logic [31:0] epcd);
        vec_t v;
        v.st = st; v.fl = fl; v.pc = pc; v.tgt = tgt; v.rdy = rdy; v.go = go;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.einstr = einstr; v.epcd = epcd;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " imem_req"}, {31'd0, bus.imem_req}, 32'd0);
        chk({tag, " imem_addr"}, bus.imem_addr, 32'h0000_0100);
        chk({tag, " InstrD"}, InstrD, 32'h0000_0013);
        chk({tag, " PCD"}, PCD, 32'd0);
        chk({tag, " PCPlus4D"}, PCPlus4D, 32'd4);
        chk({tag, " ValidD"}, {31'd0, ValidD}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Inputs during the cycle -> outputs expected just after the following edge.
        //   st fl pc target        rdy go | req addr         valid instr         pcd
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h100,      0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  0, 32'h100,      0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h104,      1, 32'hA5A5_0100,  32'h100);
        add(0, 0, 0, 32'h0,         1, 1,  0, 32'h104,      0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h108,      1, 32'hA5A5_0104,  32'h104);
        add(1, 0, 0, 32'h0,         1, 1,  0, 32'h108,      1, 32'hA5A5_0104,  32'h104);
        add(1, 0, 0, 32'h0,         1, 1,  0, 32'h108,      1, 32'hA5A5_0104,  32'h104);
        add(1, 0, 0, 32'h0,         1, 1,  0, 32'h108,      1, 32'hA5A5_0104,  32'h104);
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h10C,      1, 32'hA5A5_0108,  32'h108);
        add(0, 0, 0, 32'h0,         1, 1,  0, 32'h10C,      0, 32'h13,         32'h0);
        add(0, 0, 1, 32'h200,       1, 0,  0, 32'h200,      0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h200,      0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  0, 32'h200,      0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h204,      1, 32'hA5A5_0200,  32'h200);
        add(0, 0, 1, 32'h300,       1, 1,  0, 32'h300,      0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h300,      0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  0, 32'h300,      0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h304,      1, 32'hA5A5_0300,  32'h300);
        add(0, 0, 1, 32'hFFFF_FFFE, 0, 1,  1, 32'hFFFF_FFFC, 0, 32'h13,        32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  0, 32'hFFFF_FFFC, 0, 32'h13,        32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h0,        1, 32'h5A5A_FFFC,  32'hFFFF_FFFC);
        add(1, 1, 0, 32'h0,         1, 1,  0, 32'h0,        0, 32'h13,         32'h0);
        add(0, 1, 0, 32'h0,         1, 1,  1, 32'h0,        0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  0, 32'h0,        0, 32'h13,         32'h0);
        add(1, 0, 0, 32'h0,         1, 1,  0, 32'h0,        0, 32'h13,         32'h0);
        add(0, 1, 0, 32'h0,         1, 1,  1, 32'h0,        0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  0, 32'h0,        0, 32'h13,         32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  1, 32'h4,        1, 32'hA5A5_0000,  32'h0);
        add(0, 0, 0, 32'h0,         1, 1,  0, 32'h4,        0, 32'h13,         32'h0);

        rst = 1'b1;
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        mem_ready = 1'b1; mem_go = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        foreach (vq[i]) begin
            StallD    = vq[i].st;
            FlushD    = vq[i].fl;
            PCSrcE    = vq[i].pc;
            PCTargetE = vq[i].tgt;
            mem_ready = vq[i].rdy;
            mem_go    = vq[i].go;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d imem_req", i), {31'd0, bus.imem_req}, {31'd0, vq[i].ereq});
            chk($sformatf("v%0d imem_addr", i), bus.imem_addr, vq[i].eaddr);
            chk($sformatf("v%0d ValidD", i), {31'd0, ValidD}, {31'd0, vq[i].evalid});
            chk($sformatf("v%0d InstrD", i), InstrD, vq[i].einstr);
            if (vq[i].evalid) begin
                chk($sformatf("v%0d PCD", i), PCD, vq[i].epcd);
                chk($sformatf("v%0d PCPlus4D", i), PCPlus4D, vq[i].epcd + 32'd4);
            end
            @(negedge clk);
        end

        // Asynchronous reset in WAIT with a response still owed by memory.
        StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        mem_ready = 1'b1; mem_go = 1'b1;
        rst = 1'b1;
        #1;
        chk_reset("async reset");
        #2;
        rst = 1'b0;
        // The late response lands while the DUT is in IDLE and must be ignored.
        @(posedge clk);
        #1;
        chk("post-reset imem_req", {31'd0, bus.imem_req}, 32'd1);
        chk("post-reset imem_addr", bus.imem_addr, 32'h0000_0100);
        chk("post-reset ValidD", {31'd0, ValidD}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("post-reset ValidD fetched", {31'd0, ValidD}, 32'd1);
        chk("post-reset InstrD", InstrD, 32'hA5A5_0100);
        chk("post-reset PCD", PCD, 32'h0000_0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
